// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the RV32I data-memory path: funct3 codes, responder
// states and the store byte-lane mask.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} mem_state_t;

    // Little-endian lanes touched by a store of the given size at addr[1:0].
    function automatic logic [3:0] lane_mask(input logic [2:0] funct3,
                                             input logic [1:0] addr_lo);
        case (funct3)
            F3_B:    lane_mask = 4'b0001 << addr_lo;
            F3_H:    lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            F3_W:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between the core (master) and the
// data-memory responder (slave).
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a memory word and applies RV32I
// sign or zero extension; shared with future cache read paths.
module load_extend
    import riscv_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_W:    data = word;
            F3_BU:   data = {24'd0, byte_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle RV32I data memory: one request at a time, programmable wait
// states, byte-lane stores, extended loads and an error response.
module data_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [31:0] mem [DEPTH];

    mem_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [IDX_W-1:0] idx;
    logic [31:0] rd_word;
    logic [31:0] load_data;
    logic [31:0] wdata_lanes;
    logic [3:0]  mask;
    logic        access_err;
    logic        do_write;

    assign idx     = addr_q[IDX_W+1:2];
    assign rd_word = mem[idx];
    assign mask    = lane_mask(f3_q, addr_q[1:0]);

    load_extend u_load_extend (
        .word    (rd_word),
        .addr_lo (addr_q[1:0]),
        .funct3  (f3_q),
        .data    (load_data)
    );

    // Upper address bits only feed the range check; the index never wraps.
    always_comb begin
        access_err = 1'b0;
        if ((addr_q >> (IDX_W + 2)) != 32'd0) access_err = 1'b1;
        case (f3_q)
            F3_B, F3_BU: begin end
            F3_H, F3_HU: if (addr_q[0]) access_err = 1'b1;
            F3_W:        if (addr_q[1:0] != 2'b00) access_err = 1'b1;
            default:     access_err = 1'b1;
        endcase
        if (we_q && (f3_q == F3_BU || f3_q == F3_HU)) access_err = 1'b1;
    end

    always_comb begin
        case (f3_q)
            F3_B:    wdata_lanes = {4{wdata_q[7:0]}};
            F3_H:    wdata_lanes = {2{wdata_q[15:0]}};
            default: wdata_lanes = wdata_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        do_write = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = ACCESS;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ACCESS: begin
                err_d    = access_err;
                rdata_d  = (access_err || we_q) ? 32'd0 : load_data;
                do_write = we_q && !access_err;
                state_d  = RESP;
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (state_q == IDLE && bus.req_valid) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                f3_q    <= bus.req_funct3;
            end
        end
    end

    // Array is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (do_write && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) mem[idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
            end
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expected responses are queued when
// a request is accepted and compared when the response handshake happens.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WAIT_CYCLES = 2;
    localparam logic [2:0] F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100, F3_HU = 3'b101;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] f3, input logic [31:0] exp_rdata,
                            input logic exp_err, input logic hold);
        int t = 0;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_funct3 = f3;
        bus.req_valid  = 1'b1;
        while (!bus.req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.req_ready) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        sb.push_back('{rdata: exp_rdata, err: exp_err});
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp();
        int lat = 1;
        while (!bus.resp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check_eq("latency", lat, WAIT_CYCLES + 2);
    endtask

    task automatic finish_resp();
        exp_t e;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        bus.resp_ready = 1'b1;
        check_eq("rdata", bus.resp_rdata, e.rdata);
        check_eq("err", {31'd0, bus.resp_err}, {31'd0, e.err});
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check_eq("resp_drop", {31'd0, bus.resp_valid}, 32'd0);
        check_eq("ready_back", {31'd0, bus.req_ready}, 32'd1);
    endtask

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, input logic [31:0] exp_rdata, input logic exp_err);
        send_req(we, addr, wdata, f3, exp_rdata, exp_err, 1'b0);
        wait_resp();
        finish_resp();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        check_eq({tag, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
        check_eq({tag, "_rdata"}, bus.resp_rdata, 32'd0);
        check_eq({tag, "_err"}, {31'd0, bus.resp_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.req_funct3 = 3'd0;
        bus.resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 check_reset_outputs("reset");
        @(negedge clk);

        txn(1'b1, 32'h10, 32'hDEADBEEF, F3_W, 32'h0, 1'b0);
        txn(1'b0, 32'h10, 32'h0, F3_W, 32'hDEADBEEF, 1'b0);

        txn(1'b1, 32'h13, 32'h00000080, F3_B, 32'h0, 1'b0);
        txn(1'b0, 32'h13, 32'h0, F3_B, 32'hFFFFFF80, 1'b0);
        txn(1'b0, 32'h13, 32'h0, F3_BU, 32'h00000080, 1'b0);
        txn(1'b0, 32'h10, 32'h0, F3_W, 32'h80ADBEEF, 1'b0);
        txn(1'b0, 32'h12, 32'h0, F3_H, 32'hFFFF80AD, 1'b0);
        txn(1'b0, 32'h10, 32'h0, F3_HU, 32'h0000BEEF, 1'b0);

        txn(1'b1, 32'h14, 32'h0, F3_W, 32'h0, 1'b0);
        txn(1'b1, 32'h16, 32'h1234ABCD, F3_H, 32'h0, 1'b0);
        txn(1'b0, 32'h14, 32'h0, F3_W, 32'hABCD0000, 1'b0);

        // Misaligned, out-of-range and illegal encodings; memory must not change.
        txn(1'b0, 32'h11, 32'h0, F3_H, 32'h0, 1'b1);
        txn(1'b1, 32'h12, 32'h11111111, F3_W, 32'h0, 1'b1);
        txn(1'b0, 32'h10, 32'h0, F3_W, 32'h80ADBEEF, 1'b0);
        txn(1'b0, 4 * DEPTH, 32'h0, F3_W, 32'h0, 1'b1);
        txn(1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1);
        txn(1'b1, 32'h10, 32'h00000055, F3_BU, 32'h0, 1'b1);
        txn(1'b0, 32'h10, 32'h0, F3_W, 32'h80ADBEEF, 1'b0);

        // Backpressure with a request held on the bus the whole time.
        send_req(1'b0, 32'h10, 32'h0, F3_W, 32'h80ADBEEF, 1'b0, 1'b1);
        wait_resp();
        for (int i = 0; i < 10; i++) begin
            check_eq("bp_valid", {31'd0, bus.resp_valid}, 32'd1);
            check_eq("bp_rdata", bus.resp_rdata, 32'h80ADBEEF);
            check_eq("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
            @(negedge clk);
        end
        finish_resp();
        send_req(1'b0, 32'h10, 32'h0, F3_W, 32'h80ADBEEF, 1'b0, 1'b0);
        wait_resp();
        finish_resp();

        // Reset during the wait states of a store: the store must be dropped.
        txn(1'b1, 32'h20, 32'h0, F3_W, 32'h0, 1'b0);
        send_req(1'b1, 32'h20, 32'h12345678, F3_W, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        #1 check_reset_outputs("midrst");
        void'(sb.pop_front());
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        txn(1'b0, 32'h20, 32'h0, F3_W, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
